// File: rtl/ms_wb_slice_tmo_if.sv
// Wishbone classic bus bundle used on both sides of the registered slice.
// The master drives the request fields; the slave returns read data and acknowledge.
interface ms_wb_slice_tmo_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/ms_wb_slice_tmo.sv
// Registered Wishbone slice between the management master and the user-area decoder.
// A transfer the IP does not acknowledge in time ends locally with ERR_DATA and a sticky flag.
//
// state | meaning
// IDLE  | no transfer outstanding; a strobed cycle is latched and issued
// REQ   | request held on m_wb, waiting for ack, abort or timeout
// RESP  | s_wb ack pulse for the completed (or timed-out) transfer
module ms_wb_slice_tmo #(
  parameter int unsigned TMO_CYCLES = 255,
  parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ms_wb_slice_tmo_if.slave    s_wb,
  ms_wb_slice_tmo_if.master   m_wb,
  input  logic                tmo_clr_i,
  output logic                tmo_o,
  output logic [31:0]         tmo_adr_o
);

  localparam int unsigned CNT_W = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TMO_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_q, bus_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       adr_q, adr_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [31:0]       rdat_q, rdat_d;
  logic              ack_q, ack_d;
  logic              tmo_q, tmo_d;
  logic [31:0]       tmo_adr_q, tmo_adr_d;
  logic              tmo_set;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bus_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      wdat_q    <= '0;
      rdat_q    <= '0;
      ack_q     <= 1'b0;
      tmo_q     <= 1'b0;
      tmo_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_q     <= bus_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      rdat_q    <= rdat_d;
      ack_q     <= ack_d;
      tmo_q     <= tmo_d;
      tmo_adr_q <= tmo_adr_d;
    end
  end

  // Timeout timer counts down from TMO_CYCLES-1; reaching zero in REQ is the last allowed cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bus_d     = bus_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    rdat_d    = rdat_q;
    ack_d     = 1'b0;
    tmo_adr_d = tmo_adr_q;
    tmo_set   = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_wb.cyc && s_wb.stb) begin
          we_d    = s_wb.we;
          sel_d   = s_wb.sel;
          adr_d   = s_wb.adr;
          wdat_d  = s_wb.dat_w;
          bus_d   = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = REQ;
        end
      end
      REQ: begin
        if (!s_wb.cyc) begin
          bus_d   = 1'b0;
          state_d = IDLE;
        end else if (m_wb.ack) begin
          rdat_d  = m_wb.dat_r;
          bus_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = RESP;
        end else if (cnt_q == '0) begin
          rdat_d    = ERR_DATA;
          bus_d     = 1'b0;
          ack_d     = 1'b1;
          tmo_set   = 1'b1;
          tmo_adr_d = adr_q;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    tmo_d = tmo_set | (tmo_q & ~tmo_clr_i);
  end

  assign m_wb.cyc   = bus_q;
  assign m_wb.stb   = bus_q;
  assign m_wb.we    = we_q;
  assign m_wb.sel   = sel_q;
  assign m_wb.adr   = adr_q;
  assign m_wb.dat_w = wdat_q;
  assign s_wb.ack   = ack_q;
  assign s_wb.dat_r = rdat_q;
  assign tmo_o      = tmo_q;
  assign tmo_adr_o  = tmo_adr_q;

endmodule
